arm_regfile_extend: RTL and testbench
=====================================

# arm_regfile_extend

Register-file and immediate-extension slice of the single-cycle ARM datapath. It sits between instruction decode and the ALU. It provides:
- two combinational read ports (SrcA/RD2 sources);
- one clocked write port for the writeback Result;
- R15 aliased to the externally supplied PC+8;
- a combinational extend unit that turns Instr[23:0] into a 32-bit immediate for the ALU-source mux or branch-target adder.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits, with 4-bit register addresses.

Ports:
- clk  in  1  sole clock; all register writes happen on its rising edge.
- reset  in  1  asynchronous, active-low; while low, R0–R14 are held at 0.
- WE3  in  1  write enable for port 3.
- RA1  in  4  read address, port 1.
- RA2  in  4  read address, port 2.
- WA3  in  4  write address, port 3.
- WD3  in  32  write data, port 3 (writeback Result).
- R15  in  32  PC+8 value, returned when register 15 is read.
- RD1  out  32  read data, port 1 (SrcA).
- RD2  out  32  read data, port 2 (SrcB / WriteData source).
- Instr  in  24  instruction bits [23:0].
- ImmSrc  in  2  immediate format select.
- ExtImm  out  32  extended immediate.

## Operation
Storage:
- 15 architectural registers, R0–R14, each 32 bits. There is no storage for R15.

Reads (combinational, no clock):
- RDn = R15 input when RAn = 4'hF; otherwise RDn = register[RAn].
- Both ports are independent. RA1 = RA2 is legal and returns the same value on both ports.

Write:
- On the rising edge of clk, with reset high and WE3 = 1 and WA3 ≠ 4'hF: register[WA3] <= WD3.
- A write with WA3 = 4'hF is silently discarded. R15 is owned by the PC logic.
- When WE3 = 0, no register changes.

Extend (combinational), as a function of ImmSrc:
- 2'b00: ExtImm = {24'b0, Instr[7:0]}. Data-processing 8-bit immediate, zero-extended.
- 2'b01: ExtImm = {20'b0, Instr[11:0]}. LDR/STR 12-bit offset, zero-extended.
- 2'b10: ExtImm = {{6{Instr[23]}}, Instr[23:0], 2'b00}. Branch offset, sign-extended and word-scaled.
- 2'b11: ExtImm = 32'h0000_0000. Reserved encoding.
- The extend unit has no state and ignores clk and reset.

## Timing
Reset:
- Reset is asynchronous. A falling edge of reset clears R0–R14 immediately, without waiting for clk.
- While reset is low, writes are blocked.
- Reads during reset return 0 for R0–R14 and the R15 input for address 15.
- Reset may be asserted mid-operation. Any write in progress on that cycle is lost, and every register reads 0 thereafter.
- After reset is released, the first write takes effect on the next rising clk edge with WE3 = 1.

Reset value of outputs:
- RD1 and RD2 are 0 for any address other than 15.
- ExtImm always follows Instr and ImmSrc.

Latency:
- Reads are 0 cycles: combinational from RA, R15 and the register contents.
- Writes are 1 cycle: the new value is visible on RD1/RD2 right after the rising edge that commits it.

Read-during-write to the same address:
- Before the edge, the read port returns the old value. There is no write-to-read bypass.
- After the edge, it returns the new value.

Arithmetic:
- No arithmetic beyond the extension rules above.
- The branch result wraps naturally in 32 bits, e.g. Instr = 24'hFFFFFF gives ExtImm = 32'hFFFF_FFFC.

## Test plan
- Reset then read: pull reset low, release, set RA1 = 2 and RA2 = 14 -> RD1 = 0, RD2 = 0. Set RA1 = 15 with R15 = 32'h0000_0010 -> RD1 = 32'h10.
- MOV/ADD sequence: write R2 = 5, then R3 = 4, one clk edge each with WE3 = 1. Set RA1 = 2, RA2 = 3 -> RD1 = 5, RD2 = 4. Write WD3 = 9 to WA3 = 4 -> RA1 = 4 reads 9 after the edge.
- Write gating:
  - WE3 = 0 with WA3 = 2, WD3 = 32'hDEAD_BEEF -> R2 stays 5.
  - WE3 = 1 with WA3 = 15, WD3 = 32'h1234 -> RA1 = 15 still returns the R15 input.
- Same-cycle read/write: RA1 = WA3 = 7, WD3 = 32'hA5A5_A5A5, WE3 = 1 -> RD1 = old value before the edge and 32'hA5A5_A5A5 after it.
- Async reset mid-run: with R2 = 5 loaded, drop reset between clock edges -> RD1 (RA1 = 2) goes to 0 with no clk edge. An edge with WE3 = 1 while reset is low does not write.
- Extend, with Instr = 24'h80_0A05:
  - ImmSrc = 00 -> 32'h0000_0005;
  - ImmSrc = 01 -> 32'h0000_0A05;
  - ImmSrc = 10 -> 32'hFE00_2814;
  - ImmSrc = 11 -> 0.
- Extend, with Instr = 24'h00_0002 and ImmSrc = 10 -> 32'h0000_0008.

Source files
------------

// File: rtl/arm_regfile_extend.sv
// Register file (R0-R14, R15 aliased to PC+8) and immediate extend unit
// for the single-cycle ARM datapath, between decode and the ALU.
module arm_regfile_extend (
   input  logic        clk,
   input  logic        reset,
   input  logic        WE3,
   input  logic [3:0]  RA1,
   input  logic [3:0]  RA2,
   input  logic [3:0]  WA3,
   input  logic [31:0] WD3,
   input  logic [31:0] R15,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   input  logic [23:0] Instr,
   input  logic [1:0]  ImmSrc,
   output logic [31:0] ExtImm
);

   localparam logic [3:0] PC_ADDR = 4'hF;

   logic [31:0] rf [0:14];

   // Immediate formats: DP imm8, LDR/STR imm12, word-scaled signed branch offset.
   function automatic logic [31:0] extend_imm(input logic [23:0] instr,
                                              input logic [1:0]  src);
      logic signed [25:0] boff;
      boff = $signed({instr, 2'b00});
      case (src)
         2'b00:   extend_imm = {24'b0, instr[7:0]};
         2'b01:   extend_imm = {20'b0, instr[11:0]};
         2'b10:   extend_imm = 32'(boff);
         default: extend_imm = 32'h0000_0000;
      endcase
   endfunction

   // Writes to R15 are dropped; the PC logic owns that register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 15; i++) rf[i] <= '0;
      end else if (WE3 && (WA3 != PC_ADDR)) begin
         rf[WA3] <= WD3;
      end
   end

   always_comb begin
      RD1 = (RA1 == PC_ADDR) ? R15 : rf[RA1];
      RD2 = (RA2 == PC_ADDR) ? R15 : rf[RA2];
   end

   assign ExtImm = extend_imm(Instr, ImmSrc);

endmodule

// File: tb/tb_arm_regfile_extend.sv
// Scoreboard bench for arm_regfile_extend: register reads/writes, reset, extend.
module tb_arm_regfile_extend;

   logic        clk = 1'b0;
   logic        reset;
   logic        WE3;
   logic [3:0]  RA1, RA2, WA3;
   logic [31:0] WD3, R15, RD1, RD2, ExtImm;
   logic [23:0] Instr;
   logic [1:0]  ImmSrc;

   typedef enum {P_RD1, P_RD2, P_EXT} port_e;
   typedef struct {
      string       tag;
      port_e       port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] model [0:14];

   arm_regfile_extend dut (
      .clk(clk), .reset(reset), .WE3(WE3), .RA1(RA1), .RA2(RA2), .WA3(WA3),
      .WD3(WD3), .R15(R15), .RD1(RD1), .RD2(RD2), .Instr(Instr),
      .ImmSrc(ImmSrc), .ExtImm(ExtImm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input port_e p, input logic [31:0] e);
      exp_t x;
      x.tag = tag; x.port = p; x.exp = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t        x;
      logic [31:0] got;
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         case (x.port)
            P_RD1:   got = RD1;
            P_RD2:   got = RD2;
            default: got = ExtImm;
         endcase
         check(x.tag, got, x.exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [3:0] a);
      return (a == 4'hF) ? R15 : model[a];
   endfunction

   task automatic rd(input string tag, input logic [3:0] a1, input logic [3:0] a2);
      RA1 = a1; RA2 = a2;
      push({tag, "_rd1"}, P_RD1, ref_rd(a1));
      push({tag, "_rd2"}, P_RD2, ref_rd(a2));
      drain();
   endtask

   task automatic wr(input logic [3:0] wa, input logic [31:0] wd, input logic we);
      @(negedge clk);
      WE3 = we; WA3 = wa; WD3 = wd;
      @(posedge clk);
      if (we && wa != 4'hF && reset) model[wa] = wd;
      #1 WE3 = 1'b0;
   endtask

   task automatic ext(input string tag, input logic [23:0] ins, input logic [1:0] src,
                      input logic [31:0] e);
      Instr = ins; ImmSrc = src;
      push(tag, P_EXT, e);
      drain();
   endtask

   initial begin
      logic [23:0] ins;
      logic [31:0] e;
      reset = 1'b0; WE3 = 1'b0; RA1 = '0; RA2 = '0; WA3 = '0; WD3 = '0;
      R15 = 32'h0000_0010; Instr = '0; ImmSrc = '0;
      for (int i = 0; i < 15; i++) model[i] = '0;

      // reset state, reads during and after reset
      #12;
      rd("in_reset", 4'd2, 4'd15);
      reset = 1'b1;
      #3;
      rd("post_reset", 4'd2, 4'd14);
      rd("r15_alias", 4'd15, 4'd0);

      // MOV/ADD sequence
      wr(4'd2, 32'd5, 1'b1);
      wr(4'd3, 32'd4, 1'b1);
      rd("mov_add", 4'd2, 4'd3);
      wr(4'd4, 32'd9, 1'b1);
      rd("wr_r4", 4'd4, 4'd4);

      // write gating
      wr(4'd2, 32'hDEAD_BEEF, 1'b0);
      rd("we_off", 4'd2, 4'd3);
      wr(4'd15, 32'h1234, 1'b1);
      rd("wa15_drop", 4'd15, 4'd2);

      // same-cycle read/write: old before edge, new after
      wr(4'd7, 32'h1111_2222, 1'b1);
      @(negedge clk);
      RA1 = 4'd7; WA3 = 4'd7; WD3 = 32'hA5A5_A5A5; WE3 = 1'b1;
      push("rdw_before", P_RD1, 32'h1111_2222);
      drain();
      @(posedge clk);
      #1 WE3 = 1'b0;
      model[7] = 32'hA5A5_A5A5;
      push("rdw_after", P_RD1, 32'hA5A5_A5A5);
      drain();

      // random writes against the model
      for (int i = 0; i < 30; i++)
         wr(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      R15 = 32'h0000_8008;
      for (int a = 0; a < 16; a++) rd("rand", 4'(a), 4'(15 - a));

      // async reset between edges, then a blocked write
      wr(4'd2, 32'd5, 1'b1);
      rd("pre_areset", 4'd2, 4'd2);
      @(negedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 15; i++) model[i] = '0;
      rd("areset", 4'd2, 4'd15);
      wr(4'd2, 32'd77, 1'b1);
      rd("blocked_wr", 4'd2, 4'd7);
      #2 reset = 1'b1;
      wr(4'd2, 32'd33, 1'b1);
      rd("after_release", 4'd2, 4'd3);

      // extend unit
      ext("ext_00", 24'h80_0A05, 2'b00, 32'h0000_0005);
      ext("ext_01", 24'h80_0A05, 2'b01, 32'h0000_0A05);
      ext("ext_10", 24'h80_0A05, 2'b10, 32'hFE00_2814);
      ext("ext_11", 24'h80_0A05, 2'b11, 32'h0000_0000);
      ext("ext_br_pos", 24'h00_0002, 2'b10, 32'h0000_0008);
      ext("ext_br_wrap", 24'hFF_FFFF, 2'b10, 32'hFFFF_FFFC);
      for (int i = 0; i < 12; i++) begin
         ins = 24'($urandom);
         case (i % 4)
            0:       e = 32'(ins & 24'hFF);
            1:       e = 32'(ins & 24'hFFF);
            2:       e = 32'($signed(ins) * 4);
            default: e = 32'h0;
         endcase
         ext("ext_rand", ins, 2'(i % 4), e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
